// File: rtl/adc_trig_capture_pkg.sv
// Shared definitions for the triggered ADC capture engine: FSM state encodings,
// trigger mode codes and the trigger-condition helper.
package adc_trig_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } cap_state_e;

  localparam logic [1:0] TRIG_RISE = 2'b00;
  localparam logic [1:0] TRIG_FALL = 2'b01;
  localparam logic [1:0] TRIG_EXT  = 2'b10;
  localparam logic [1:0] TRIG_IMM  = 2'b11;

  // Samples are zero-extended to 16 bits so one helper serves every DATA_W.
  function automatic logic trig_hit(
    input logic [1:0]  mode,
    input logic [15:0] cur,
    input logic [15:0] prev,
    input logic [15:0] level,
    input logic        prev_ok,
    input logic        ext
  );
    logic hit;
    case (mode)
      TRIG_RISE: hit = prev_ok && (prev < level) && (cur >= level);
      TRIG_FALL: hit = prev_ok && (prev >= level) && (cur < level);
      TRIG_EXT:  hit = ext;
      TRIG_IMM:  hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/adc_trig_capture_ram.sv
// Simple dual-port capture buffer: one write port, registered read port
// (1-cycle latency); the read register holds its value until the next read.
module adc_trig_capture_ram #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write port; the storage array itself is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read; only the output register clears on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/adc_trig_capture.sv
// Triggered ADC capture engine: circular pre/post-trigger buffer replayed in time order.
// Defining ADC_CAP_DECIM_EN adds the decim port (keep every (decim+1)-th strobe).
module adc_trig_capture
  import adc_trig_capture_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              ext_trig,
  input  logic [ADDR_W-1:0] pretrig,
`ifdef ADC_CAP_DECIM_EN
  input  logic [7:0]        decim,
`endif
  input  logic              rd_next,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  cap_state_e        state_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] pt_r;
  logic [1:0]        mode_r;
  logic [DATA_W-1:0] level_r;
  logic [DATA_W-1:0] prev_r;
  logic              prev_ok_r;

  logic              capturing_s;
  logic              arm_take_s;
  logic              rd_take_s;
  logic              smp_take_s;
  logic              phase_ok_s;
  logic              hit_s;
  logic              pre_last_s;
  logic              post_last_s;
  logic [ADDR_W-1:0] post_len_s;

`ifdef ADC_CAP_DECIM_EN
  logic [7:0] decim_r;
  logic [7:0] dcnt_r;

  // Decimation phase restarts at arm, so the first strobe of a capture is always kept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      decim_r <= 8'd0;
      dcnt_r  <= 8'd0;
    end else if (arm_take_s) begin
      decim_r <= decim;
      dcnt_r  <= 8'd0;
    end else if (smp_valid && capturing_s && !abort) begin
      dcnt_r <= (dcnt_r == decim_r) ? 8'd0 : dcnt_r + 8'd1;
    end
  end

  assign phase_ok_s = (dcnt_r == 8'd0);
`else
  assign phase_ok_s = 1'b1;
`endif

  // Qualified strobes and end-of-phase detection; abort masks everything else.
  always_comb begin
    capturing_s = (state_r == ST_PRE) || (state_r == ST_WAIT) || (state_r == ST_POST);
    arm_take_s  = arm && !abort && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    rd_take_s   = rd_next && !abort && (state_r == ST_DONE);
    smp_take_s  = smp_valid && phase_ok_s && capturing_s && !abort;
    // DEPTH is a power of two, so DEPTH-1-pt is the bitwise complement of pt.
    post_len_s  = ~pt_r;
    pre_last_s  = (cnt_r == (pt_r - ADDR_ONE));
    post_last_s = (cnt_r == (post_len_s - ADDR_ONE));
    hit_s       = (state_r == ST_WAIT) && smp_take_s &&
                  trig_hit(mode_r, 16'(smp_data), 16'(prev_r), 16'(level_r), prev_ok_r, ext_trig);
  end

  // Capture FSM with pointer/counter bookkeeping and registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      wr_ptr_r  <= ADDR_ZERO;
      rd_ptr_r  <= ADDR_ZERO;
      cnt_r     <= ADDR_ZERO;
      pt_r      <= ADDR_ZERO;
      mode_r    <= TRIG_RISE;
      level_r   <= {DATA_W{1'b0}};
      prev_r    <= {DATA_W{1'b0}};
      prev_ok_r <= 1'b0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      trig_addr <= ADDR_ZERO;
    end else begin
      rd_valid <= rd_take_s;
      if (smp_take_s) begin
        wr_ptr_r  <= wr_ptr_r + ADDR_ONE;
        prev_r    <= smp_data;
        prev_ok_r <= 1'b1;
      end
      // The frame is exactly DEPTH long, so natural wrap restarts the replay.
      if (rd_take_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_ONE;
      end

      if (abort) begin
        state_r <= ST_IDLE;
        busy    <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE, ST_DONE: begin
            if (arm) begin
              pt_r      <= pretrig;
              mode_r    <= trig_mode;
              level_r   <= trig_level;
              cnt_r     <= ADDR_ZERO;
              prev_ok_r <= 1'b0;
              busy      <= 1'b1;
              done      <= 1'b0;
              state_r   <= (pretrig == ADDR_ZERO) ? ST_WAIT : ST_PRE;
            end
          end
          ST_PRE: begin
            if (smp_take_s) begin
              cnt_r <= cnt_r + ADDR_ONE;
              if (pre_last_s) begin
                state_r <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (hit_s) begin
              trig_addr <= wr_ptr_r;
              rd_ptr_r  <= wr_ptr_r - pt_r;
              cnt_r     <= ADDR_ZERO;
              if (post_len_s == ADDR_ZERO) begin
                state_r <= ST_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                state_r <= ST_POST;
              end
            end
          end
          ST_POST: begin
            if (smp_take_s) begin
              cnt_r <= cnt_r + ADDR_ONE;
              if (post_last_s) begin
                state_r <= ST_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

  adc_trig_capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .we     (smp_take_s),
    .waddr  (wr_ptr_r),
    .wdata  (smp_data),
    .re     (rd_take_s),
    .raddr  (rd_ptr_r),
    .rdata  (rd_data)
  );

endmodule

// File: tb/tb_adc_trig_capture.sv
// Scoreboard bench for adc_trig_capture (DEPTH=16, DATA_W=8); the decimation
// scenario is compiled in only when ADC_CAP_DECIM_EN is defined.
module tb_adc_trig_capture;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       resetn;
  logic       smp_valid;
  logic [7:0] smp_data;
  logic       arm;
  logic       abort;
  logic [1:0] trig_mode;
  logic [7:0] trig_level;
  logic       ext_trig;
  logic [3:0] pretrig;
  logic       rd_next;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic [3:0] trig_addr;
`ifdef ADC_CAP_DECIM_EN
  logic [7:0] decim;
`endif

  adc_trig_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .smp_valid  (smp_valid),
    .smp_data   (smp_data),
    .arm        (arm),
    .abort      (abort),
    .trig_mode  (trig_mode),
    .trig_level (trig_level),
    .ext_trig   (ext_trig),
    .pretrig    (pretrig),
`ifdef ADC_CAP_DECIM_EN
    .decim      (decim),
`endif
    .rd_next    (rd_next),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done),
    .trig_addr  (trig_addr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: 0 idle, 1 pre, 2 wait, 3 post, 4 done
  logic [7:0] m_mem [DEPTH];
  int         m_state;
  logic [3:0] m_wr, m_trig, m_pt, m_rdk;
  int         m_cnt, m_decim, m_dcnt;
  logic [1:0] m_mode;
  logic [7:0] m_level, m_prev;
  bit         m_prev_ok;
  logic [7:0] exp_q [$];

  task automatic model_reset();
    m_state = 0; m_wr = 4'd0; m_trig = 4'd0; m_pt = 4'd0; m_rdk = 4'd0;
    m_cnt = 0; m_decim = 0; m_dcnt = 0; m_mode = 2'b00; m_level = 8'd0;
    m_prev = 8'd0; m_prev_ok = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), (m_state >= 1 && m_state <= 3) ? 32'd1 : 32'd0);
    check_eq({tag, "_done"}, 32'(done), (m_state == 4) ? 32'd1 : 32'd0);
  endtask

  task automatic arm_cap(input logic [3:0] pt, input logic [1:0] mode, input logic [7:0] lvl, input int dec);
    pretrig = pt; trig_mode = mode; trig_level = lvl; arm = 1'b1;
`ifdef ADC_CAP_DECIM_EN
    decim = 8'(dec);
`endif
    if (m_state == 0 || m_state == 4) begin
      m_pt = pt; m_mode = mode; m_level = lvl; m_decim = dec;
      m_dcnt = 0; m_cnt = 0; m_prev_ok = 1'b0;
      m_state = (pt == 4'd0) ? 2 : 1;
    end
    @(posedge clk); #1;
    arm = 1'b0;
    check_status("arm");
  endtask

  task automatic send(input logic [7:0] s, input logic e);
    bit take;
    bit hit;
    smp_valid = 1'b1; smp_data = s; ext_trig = e;
    if (m_state >= 1 && m_state <= 3) begin
      take   = (m_dcnt == 0);
      m_dcnt = (m_dcnt == m_decim) ? 0 : m_dcnt + 1;
      if (take) begin
        m_mem[m_wr] = s;
        if (m_state == 1) begin
          m_cnt++;
          if (m_cnt == int'(m_pt)) m_state = 2;
        end else if (m_state == 2) begin
          case (m_mode)
            2'b00:   hit = m_prev_ok && (m_prev < m_level) && (s >= m_level);
            2'b01:   hit = m_prev_ok && (m_prev >= m_level) && (s < m_level);
            2'b10:   hit = e;
            default: hit = 1'b1;
          endcase
          if (hit) begin
            m_trig = m_wr; m_rdk = 4'd0; m_cnt = 0;
            m_state = (m_pt == 4'd15) ? 4 : 3;
          end
        end else begin
          m_cnt++;
          if (m_cnt == 15 - int'(m_pt)) m_state = 4;
        end
        m_wr++;
        m_prev = s;
        m_prev_ok = 1'b1;
      end
    end
    @(posedge clk); #1;
    smp_valid = 1'b0; ext_trig = 1'b0;
    check_status("smp");
  endtask

  task automatic do_read(input string tag);
    logic [3:0] idx;
    bit exp_v;
    rd_next = 1'b1;
    exp_v = (m_state == 4);
    if (exp_v) begin
      idx = m_trig - m_pt + m_rdk;
      exp_q.push_back(m_mem[idx]);
      m_rdk++;
    end
    @(posedge clk); #1;
    rd_next = 1'b0;
    check_eq(tag, 32'(rd_valid), 32'(exp_v));
  endtask

  // Output side of the scoreboard: every rd_valid must match a queued expectation.
  always @(negedge clk) begin
    if (resetn && rd_valid) begin
      if (exp_q.size() == 0) check_eq("rd_unexpected", 32'(rd_valid), 32'd0);
      else                   check_eq("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    resetn = 1'b0; smp_valid = 1'b0; smp_data = 8'd0; arm = 1'b0; abort = 1'b0;
    trig_mode = 2'b00; trig_level = 8'd0; ext_trig = 1'b0; pretrig = 4'd0; rd_next = 1'b0;
`ifdef ADC_CAP_DECIM_EN
    decim = 8'd0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_eq("rst_trig_addr", 32'(trig_addr), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    do_read("rd_idle_before");

    // Rising trigger on a wrapping ramp; readout twice to confirm replay.
    arm_cap(4'd4, 2'b00, 8'h80, 0);
    for (int i = 0; i < 40 && m_state != 4; i++) send(8'(i * 16), 1'b0);
    check_eq("rise_trig_addr", 32'(trig_addr), 32'(m_trig));
    for (int i = 0; i < 2 * DEPTH; i++) do_read("rise_rd_valid");

    // External trigger on the 10th WAIT sample, pt=0.
    arm_cap(4'd0, 2'b10, 8'h00, 0);
    for (int i = 0; i < 10; i++) send(8'(8'h05 + i * 7), (i == 9) ? 1'b1 : 1'b0);
    check_eq("ext_trig_addr", 32'(trig_addr), 32'(m_trig));
    for (int i = 0; i < 30 && m_state != 4; i++) send(8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 4; i++) do_read("ext_rd_valid");

    // Falling crossings during PRE are ignored; next one in WAIT triggers.
    arm_cap(4'd6, 2'b01, 8'h50, 0);
    for (int i = 0; i < 6; i++) send((i % 2 == 0) ? 8'h90 : 8'h10, 1'b0);
    send(8'h90, 1'b0);
    send(8'h20, 1'b0);
    check_eq("fall_trig_addr", 32'(trig_addr), 32'(m_trig));
    for (int i = 0; i < 30 && m_state != 4; i++) send(8'(8'h30 + i), 1'b0);
    for (int i = 0; i < DEPTH; i++) do_read("fall_rd_valid");

    // Abort in POST with arm and rd_next in the same cycle.
    arm_cap(4'd3, 2'b00, 8'h40, 0);
    for (int i = 0; i < 6; i++) send(8'(i * 16), 1'b0);
    abort = 1'b1; arm = 1'b1; rd_next = 1'b1;
    m_state = 0;
    @(posedge clk); #1;
    abort = 1'b0; arm = 1'b0; rd_next = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_rd_valid", 32'(rd_valid), 32'd0);
    do_read("abort_rd_after");

    // Maximum pretrig: trigger sample ends the capture directly.
    arm_cap(4'd15, 2'b11, 8'h00, 0);
    for (int i = 0; i < 16; i++) send(8'(8'hC0 + i), 1'b0);
    check_eq("clamp_trig_addr", 32'(trig_addr), 32'(m_trig));
    for (int i = 0; i < 3; i++) do_read("clamp_rd_valid");

`ifdef ADC_CAP_DECIM_EN
    // Decimation by 3: frame holds strobes 0,3,6,...
    arm_cap(4'd0, 2'b11, 8'h00, 2);
    for (int i = 0; i < 48; i++) send(8'(i), 1'b0);
    for (int i = 0; i < DEPTH; i++) do_read("decim_rd_valid");
`endif

    // Asynchronous reset mid-POST.
    arm_cap(4'd2, 2'b11, 8'h00, 0);
    for (int i = 0; i < 4; i++) send(8'(8'h11 * i), 1'b0);
    #2 resetn = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("arst_rd_data", 32'(rd_data), 32'd0);
    check_eq("arst_trig_addr", 32'(trig_addr), 32'd0);
    check_eq("q_empty", 32'(exp_q.size()), 32'd0);
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
